// File: rtl/qam16_symbol_mapper.sv
// ----------------------------------------------------------------------------
// qam16_symbol_mapper
//
// Maps the 4-bit symbol stream of the LFSR symbol generator onto Gray-coded
// 16-QAM I/Q levels and re-emits them at sample rate for a pulse-shaping
// filter. Each symbol is presented on sample phase 0; the remaining
// UPSAMPLE-1 phases carry zeros (ZERO_STUFF=1) or repeat the phase-0 value
// (ZERO_STUFF=0). Frame boundaries from the LFSR cycle marker are re-timed
// onto the symbol they belong to, and rate-handshake faults are latched.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   sym_clk_en   symbol-rate strobe (captures sym_in / cycle tag)
//   samp_clk_en  sample-rate strobe (advances the output phase)
//   sym_in       4-bit symbol: [3:2] -> I, [1:0] -> Q
//   cycle_in     LFSR cycle marker, single-clk pulse
//   out_i/out_q  signed I/Q sample, registered
//   out_valid    one-clk pulse per emitted sample
//   sym_strobe   one-clk pulse when a new symbol is placed on out_i/out_q
//   frame_start  one-clk pulse with sym_strobe on the first symbol of a frame
//   sym_count    symbols emitted since the last frame_start (wraps)
//   overrun      sticky: symbol overwritten before it was consumed
//   underrun     sticky: phase 0 reached with no pending symbol
// ----------------------------------------------------------------------------
module qam16_symbol_mapper #(
    parameter int                          OUT_WIDTH  = 18,
    parameter logic signed [OUT_WIDTH-1:0] LEVEL      = 18'sd32768,
    parameter int                          UPSAMPLE   = 4,
    parameter bit                          ZERO_STUFF = 1'b1,
    parameter int                          CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sym_clk_en,
    input  logic                        samp_clk_en,
    input  logic [3:0]                  sym_in,
    input  logic                        cycle_in,
    output logic signed [OUT_WIDTH-1:0] out_i,
    output logic signed [OUT_WIDTH-1:0] out_q,
    output logic                        out_valid,
    output logic                        sym_strobe,
    output logic                        frame_start,
    output logic [CNT_WIDTH-1:0]        sym_count,
    output logic                        overrun,
    output logic                        underrun
);

    localparam int PH_W  = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
    localparam int EXT_W = OUT_WIDTH + 2;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPSAMPLE - 1);

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_t;

    // Gray-coded level: 00 -> -3L, 01 -> -L, 11 -> +L, 10 -> +3L.
    // Built two bits wider so 3*LEVEL cannot overflow before truncation.
    function automatic logic signed [OUT_WIDTH-1:0] f_map(input logic [1:0] i_gray);
        logic signed [EXT_W-1:0] l1;
        logic signed [EXT_W-1:0] l3;
        logic signed [EXT_W-1:0] v;
        l1 = {{2{LEVEL[OUT_WIDTH-1]}}, LEVEL};
        l3 = l1 + (l1 <<< 1);
        case (i_gray)
            2'b00:   v = -l3;
            2'b01:   v = -l1;
            2'b11:   v = l1;
            default: v = l3;
        endcase
        return v[OUT_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                      r_state,     w_state_next;
    logic [PH_W-1:0]             r_phase,     w_phase_next;
    logic                        r_pend,      w_pend_next;
    logic [3:0]                  r_hold,      w_hold_next;
    logic                        r_tag,       w_tag_next;
    logic                        r_cyc_pend,  w_cyc_pend_next;
    logic signed [OUT_WIDTH-1:0] r_out_i,     w_out_i_next;
    logic signed [OUT_WIDTH-1:0] r_out_q,     w_out_q_next;
    logic                        r_valid,     w_valid_next;
    logic                        r_strobe,    w_strobe_next;
    logic                        r_frame,     w_frame_next;
    logic [CNT_WIDTH-1:0]        r_count,     w_count_next;
    logic                        r_overrun,   w_overrun_next;
    logic                        r_underrun,  w_underrun_next;

    logic                        w_consume;
    logic signed [OUT_WIDTH-1:0] w_map_i;
    logic signed [OUT_WIDTH-1:0] w_map_q;

    // Mapping works on the pre-clock holding register, so a symbol captured
    // in the same clk as a phase-0 sample is never the one emitted.
    assign w_map_i = f_map(r_hold[3:2]);
    assign w_map_q = f_map(r_hold[1:0]);

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_phase_next    = r_phase;
        w_pend_next     = r_pend;
        w_hold_next     = r_hold;
        w_tag_next      = r_tag;
        w_cyc_pend_next = r_cyc_pend;
        w_out_i_next    = r_out_i;
        w_out_q_next    = r_out_q;
        w_valid_next    = 1'b0;
        w_strobe_next   = 1'b0;
        w_frame_next    = 1'b0;
        w_count_next    = r_count;
        w_overrun_next  = r_overrun;
        w_underrun_next = r_underrun;
        w_consume       = 1'b0;

        unique case (r_state)
            StIdle: begin
                // Sample strobes are ignored until the first symbol arrives.
                if (sym_clk_en) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (samp_clk_en) begin
                    w_valid_next = 1'b1;
                    w_phase_next = (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
                    if (r_phase == '0) begin
                        if (r_pend) begin
                            w_consume     = 1'b1;
                            w_out_i_next  = w_map_i;
                            w_out_q_next  = w_map_q;
                            w_strobe_next = 1'b1;
                            w_frame_next  = r_tag;
                            w_count_next  = r_tag ? CNT_WIDTH'(1) : r_count + CNT_WIDTH'(1);
                        end else begin
                            w_out_i_next    = '0;
                            w_out_q_next    = '0;
                            w_underrun_next = 1'b1;
                        end
                    end else if (ZERO_STUFF) begin
                        w_out_i_next = '0;
                        w_out_q_next = '0;
                    end
                    // With ZERO_STUFF=0 the phase-0 value is simply kept.
                end
            end
            default: w_state_next = StIdle;
        endcase

        if (w_consume) begin
            w_pend_next = 1'b0;
        end

        // Capture runs after consume so a coincident new symbol stays pending.
        if (sym_clk_en) begin
            if (r_pend && !w_consume) begin
                w_overrun_next = 1'b1;
            end
            w_pend_next     = 1'b1;
            w_hold_next     = sym_in;
            // A marker arriving in this very clk belongs to this symbol.
            w_tag_next      = r_cyc_pend | cycle_in;
            w_cyc_pend_next = 1'b0;
        end else if (cycle_in) begin
            w_cyc_pend_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase    <= '0;
            r_pend     <= 1'b0;
            r_hold     <= '0;
            r_tag      <= 1'b0;
            r_cyc_pend <= 1'b0;
            r_out_i    <= '0;
            r_out_q    <= '0;
            r_valid    <= 1'b0;
            r_strobe   <= 1'b0;
            r_frame    <= 1'b0;
            r_count    <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_phase    <= w_phase_next;
            r_pend     <= w_pend_next;
            r_hold     <= w_hold_next;
            r_tag      <= w_tag_next;
            r_cyc_pend <= w_cyc_pend_next;
            r_out_i    <= w_out_i_next;
            r_out_q    <= w_out_q_next;
            r_valid    <= w_valid_next;
            r_strobe   <= w_strobe_next;
            r_frame    <= w_frame_next;
            r_count    <= w_count_next;
            r_overrun  <= w_overrun_next;
            r_underrun <= w_underrun_next;
        end
    end

    assign out_i       = r_out_i;
    assign out_q       = r_out_q;
    assign out_valid   = r_valid;
    assign sym_strobe  = r_strobe;
    assign frame_start = r_frame;
    assign sym_count   = r_count;
    assign overrun     = r_overrun;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_qam16_symbol_mapper.sv
// ----------------------------------------------------------------------------
// tb_qam16_symbol_mapper
//
// Two mapper instances share one stimulus stream: one zero-stuffing, one
// sample-holding. A behavioural model predicts every emitted sample and pushes
// it into a per-instance queue; a monitor pops and compares whenever the
// instance raises out_valid, and checks the sticky fault flags every cycle.
// ----------------------------------------------------------------------------
module tb_qam16_symbol_mapper;

    localparam int UPS = 4;
    localparam int LVL = 32768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       sym_clk_en;
    logic       samp_clk_en;
    logic [3:0] sym_in;
    logic       cycle_in;

    logic signed [17:0] zs_i, zs_q, hd_i, hd_q;
    logic        zs_valid, zs_strobe, zs_frame, zs_over, zs_under;
    logic        hd_valid, hd_strobe, hd_frame, hd_over, hd_under;
    logic [15:0] zs_cnt, hd_cnt;

    qam16_symbol_mapper #(.ZERO_STUFF(1'b1)) dut_zs (
        .clk(clk), .reset_n(reset_n), .sym_clk_en(sym_clk_en), .samp_clk_en(samp_clk_en),
        .sym_in(sym_in), .cycle_in(cycle_in), .out_i(zs_i), .out_q(zs_q),
        .out_valid(zs_valid), .sym_strobe(zs_strobe), .frame_start(zs_frame),
        .sym_count(zs_cnt), .overrun(zs_over), .underrun(zs_under)
    );

    qam16_symbol_mapper #(.ZERO_STUFF(1'b0)) dut_hd (
        .clk(clk), .reset_n(reset_n), .sym_clk_en(sym_clk_en), .samp_clk_en(samp_clk_en),
        .sym_in(sym_in), .cycle_in(cycle_in), .out_i(hd_i), .out_q(hd_q),
        .out_valid(hd_valid), .sym_strobe(hd_strobe), .frame_start(hd_frame),
        .sym_count(hd_cnt), .overrun(hd_over), .underrun(hd_under)
    );

    typedef struct {
        int i;
        int q;
        bit strobe;
        bit fs;
        int cnt;
    } exp_t;

    exp_t q_zs[$];
    exp_t q_hd[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit         m_run, m_pend, m_tag, m_cyc, m_over, m_under;
    int         m_phase, m_count, m_last_i, m_last_q;
    logic [3:0] m_hold;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Gray index 0..3 along the axis, then level = (2*idx-3)*LVL.
    function automatic int level(input logic [1:0] b);
        int idx;
        idx = 2 * int'(b[1]) + int'(b[1] ^ b[0]);
        return (2 * idx - 3) * LVL;
    endfunction

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_tag = 0; m_cyc = 0; m_over = 0; m_under = 0;
        m_phase = 0; m_count = 0; m_last_i = 0; m_last_q = 0; m_hold = '0;
        q_zs.delete();
        q_hd.delete();
    endtask

    // Predict the effect of one clock edge with the given inputs.
    task automatic model_step(input bit se, input bit ce, input logic [3:0] s, input bit cy);
        exp_t ez, eh;
        bit   consumed;
        consumed = 0;
        if (m_run && ce) begin
            if (m_phase == 0) begin
                if (m_pend) begin
                    consumed = 1;
                    m_last_i = level(m_hold[3:2]);
                    m_last_q = level(m_hold[1:0]);
                    m_count  = m_tag ? 1 : ((m_count + 1) % 65536);
                    ez = '{i: m_last_i, q: m_last_q, strobe: 1, fs: m_tag, cnt: m_count};
                end else begin
                    m_under  = 1;
                    m_last_i = 0;
                    m_last_q = 0;
                    ez = '{i: 0, q: 0, strobe: 0, fs: 0, cnt: m_count};
                end
                eh = ez;
            end else begin
                ez = '{i: 0, q: 0, strobe: 0, fs: 0, cnt: m_count};
                eh = '{i: m_last_i, q: m_last_q, strobe: 0, fs: 0, cnt: m_count};
            end
            q_zs.push_back(ez);
            q_hd.push_back(eh);
            m_phase = (m_phase + 1) % UPS;
        end
        if (consumed) m_pend = 0;
        if (se) begin
            if (m_pend) m_over = 1;
            m_pend = 1;
            m_hold = s;
            m_tag  = m_cyc | cy;
            m_cyc  = 0;
            m_run  = 1;
        end else if (cy) begin
            m_cyc = 1;
        end
    endtask

    task automatic tick(input bit se, input bit ce, input logic [3:0] s, input bit cy);
        sym_clk_en  = se;
        samp_clk_en = ce;
        sym_in      = s;
        cycle_in    = cy;
        model_step(se, ce, s, cy);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic cmp_sample(input string tag, input int ai, input int aq, input bit ast,
                              input bit afs, input int acnt, input exp_t e);
        chk({tag, " out_i"}, ai, e.i);
        chk({tag, " out_q"}, aq, e.q);
        chk({tag, " sym_strobe"}, int'(ast), int'(e.strobe));
        chk({tag, " frame_start"}, int'(afs), int'(e.fs));
        chk({tag, " sym_count"}, acnt, e.cnt);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " zs out_i"}, int'(zs_i), 0);
        chk({tag, " zs out_q"}, int'(zs_q), 0);
        chk({tag, " zs out_valid"}, int'(zs_valid), 0);
        chk({tag, " zs sym_strobe"}, int'(zs_strobe), 0);
        chk({tag, " zs frame_start"}, int'(zs_frame), 0);
        chk({tag, " zs sym_count"}, int'(zs_cnt), 0);
        chk({tag, " zs overrun"}, int'(zs_over), 0);
        chk({tag, " zs underrun"}, int'(zs_under), 0);
        chk({tag, " hd out_i"}, int'(hd_i), 0);
        chk({tag, " hd out_q"}, int'(hd_q), 0);
        chk({tag, " hd out_valid"}, int'(hd_valid), 0);
        chk({tag, " hd sym_count"}, int'(hd_cnt), 0);
        chk({tag, " hd overrun"}, int'(hd_over), 0);
        chk({tag, " hd underrun"}, int'(hd_under), 0);
    endtask

    // Monitor: decoupled from stimulus, pops expectations on out_valid.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (zs_valid === 1'b1) begin
                if (q_zs.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL zs unexpected sample: got out_valid=1, expected no sample (t=%0t)",
                             $time);
                end else begin
                    e = q_zs.pop_front();
                    cmp_sample("zs", int'(zs_i), int'(zs_q), zs_strobe, zs_frame, int'(zs_cnt), e);
                end
            end else begin
                chk("zs idle sym_strobe", int'(zs_strobe), 0);
                chk("zs idle frame_start", int'(zs_frame), 0);
            end
            if (hd_valid === 1'b1) begin
                if (q_hd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL hd unexpected sample: got out_valid=1, expected no sample (t=%0t)",
                             $time);
                end else begin
                    e = q_hd.pop_front();
                    cmp_sample("hd", int'(hd_i), int'(hd_q), hd_strobe, hd_frame, int'(hd_cnt), e);
                end
            end
            chk("zs overrun", int'(zs_over), int'(m_over));
            chk("zs underrun", int'(zs_under), int'(m_under));
            chk("hd overrun", int'(hd_over), int'(m_over));
            chk("hd underrun", int'(hd_under), int'(m_under));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        sym_clk_en  = 1'b0;
        samp_clk_en = 1'b0;
        sym_in      = '0;
        cycle_in    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;

        // IDLE ignores sample strobes.
        repeat (3) tick(0, 1, 4'h0, 0);

        // Full sweep 0..15, one symbol per 4 samples; frame marker before sym 8.
        for (int s = 0; s < 16; s++) begin
            tick(1, 1, 4'(s), 0);
            for (int j = 1; j < 4; j++) tick(0, 1, 4'h0, (s == 7) && (j == 2));
        end

        // Symbol captured on the same clk as each phase-0 sample.
        for (int k = 0; k < 40; k++) begin
            tick((m_phase == 0) || (k == 0), 1, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 9) == 0);
        end

        // Reach pending=1 at phase 2, then reset asynchronously mid-cycle.
        for (int k = 0; k < 16 && !(m_pend && m_phase == 2); k++) begin
            tick(m_phase == 0, 1, 4'($urandom_range(0, 15)), 0);
        end
        #1;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        model_reset();
        sym_clk_en  = 1'b0;
        samp_clk_en = 1'b0;
        cycle_in    = 1'b0;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) tick(0, 1, 4'h0, 0);

        // Normal restart.
        for (int s = 0; s < 3; s++) begin
            tick(1, 1, 4'($urandom_range(0, 15)), 0);
            for (int j = 1; j < 4; j++) tick(0, 1, 4'h0, 0);
        end

        // Overrun: two captures with no sample strobe in between.
        tick(1, 0, 4'h5, 0);
        tick(0, 0, 4'h0, 0);
        tick(1, 0, 4'hA, 0);
        repeat (4) tick(0, 1, 4'h0, 0);

        // Underrun: eight samples with no symbols.
        repeat (8) tick(0, 1, 4'h0, 0);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);
        end
        repeat (4) tick(0, 0, 4'h0, 0);

        chk("zs leftover expected samples", q_zs.size(), 0);
        chk("hd leftover expected samples", q_hd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
